// File: rtl/div_unit_if.sv
// Execute-stage divider handshake: decode controls and operands in,
// stall request, completion pulse and {HI, LO} result out.
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [63:0] result;

  // Pipeline side: issues the divide and consumes the result.
  modport master (
    output start, signed_div, a, b, cancel,
    input  busy, done, result
  );

  // Divider side.
  modport slave (
    input  start, signed_div, a, b, cancel,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-step radix-2 restoring divider for DIV/DIVU.
// Operates on magnitudes, then fixes signs on the way into DONE.
// result = {remainder (HI), quotient (LO)}.
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave dif
);

  typedef enum logic [1:0] {IDLE, CALC, DZERO, DONE} state_t;

  state_t      state, state_n;
  logic        busy_c, done_c;
  logic        accept;

  // Partial remainder is kept at 32 bits: after every restoring step it is
  // strictly below the divisor, so the 33rd bit would always be zero.
  // The 33-bit width only matters for the trial subtraction.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [4:0]  cnt;
  logic        sign_a, sign_b, sdiv;
  logic [63:0] result_q;

  logic [31:0] a_abs, b_abs;
  logic [32:0] trial;
  logic [31:0] rem_step, quo_step;
  logic [31:0] rem_fix, quo_fix, a_orig;

  assign accept = (state == IDLE) & dif.start & ~dif.cancel;
  assign a_abs  = (dif.signed_div & dif.a[31]) ? -dif.a : dif.a;
  assign b_abs  = (dif.signed_div & dif.b[31]) ? -dif.b : dif.b;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_n = state;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        busy_c = accept;
        if (accept) state_n = (dif.b == 32'd0) ? DZERO : CALC;
      end
      CALC: begin
        busy_c = 1'b1;
        if (cnt == 5'd31) state_n = DONE;
      end
      DZERO: begin
        busy_c  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Flush/exception abort overrides everything, including a new start.
    if (dif.cancel) state_n = IDLE;
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    trial    = {rem, quo[31]} - {1'b0, divisor};
    rem_step = {rem[30:0], quo[31]};
    quo_step = {quo[30:0], 1'b0};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo[30:0], 1'b1};
    end
  end

  // Sign fix-up of the final step; quo holds |a| while in DZERO, so the
  // same negation recovers the original dividend for the HI value.
  always_comb begin
    rem_fix = (sdiv & sign_a)            ? -rem_step : rem_step;
    quo_fix = (sdiv & (sign_a ^ sign_b)) ? -quo_step : quo_step;
    a_orig  = (sdiv & sign_a)            ? -quo      : quo;
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so a reset mid-divide leaves
    // no stale partial result and result reads zero straight away.
    if (rst) begin
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sdiv     <= 1'b0;
      result_q <= '0;
    end else if (!dif.cancel) begin
      case (state)
        IDLE: if (dif.start) begin
          sign_a  <= dif.a[31];
          sign_b  <= dif.b[31];
          sdiv    <= dif.signed_div;
          quo     <= a_abs;
          divisor <= b_abs;
          rem     <= '0;
          cnt     <= '0;
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) result_q <= {rem_fix, quo_fix};
        end
        DZERO: result_q <= {a_orig, 32'hFFFF_FFFF};
        default: ;
      endcase
    end
  end

  assign dif.busy   = busy_c;
  assign dif.done   = done_c;
  assign dif.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {HI, LO} and the
// completion cycle; an independent monitor pops on every done pulse.
module tb_div_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  logic [63:0] last_res;
  logic prev_done;

  div_unit_if dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  typedef struct {
    string       name;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_result"}, dif.result, e.res);
          check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end
      check("done_with_busy", {63'd0, dif.done & dif.busy}, 64'd0);
      check("done_twice", {63'd0, dif.done & prev_done}, 64'd0);
    end
    prev_done <= dif.done;
  end

  // Called at posedge+#1: issues a divide, checks busy every cycle up to and
  // including the expected done cycle, then confirms the monitor saw done.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res);
    int lat;
    int c0;
    exp_t e;
    lat = (b == 32'd0) ? 2 : 33;
    c0  = cyc;
    dif.start      = 1'b1;
    dif.signed_div = sgn;
    dif.a          = a;
    dif.b          = b;
    e.name = name;
    e.res  = res;
    e.cyc  = c0 + lat;
    sb.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check({name, "_busy"}, {63'd0, dif.busy}, {63'd0, k < lat});
      @(posedge clk);
      #1;
      if (k == 0) begin
        dif.start      = 1'b0;
        dif.a          = $urandom;
        dif.b          = $urandom;
        dif.signed_div = 1'($urandom);
      end
    end
    check({name, "_pending"}, 64'(sb.size()), 64'd0);
    sb.delete();
    last_res = res;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    prev_done      = 1'b0;
    last_res       = 64'd0;
    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.a          = 32'd0;
    dif.b          = 32'd0;
    dif.cancel     = 1'b0;

    vecs.push_back('{name:"u_100_7",    sgn:1'b0, a:32'd100,        b:32'd7,          res:{32'd2,          32'd14}});
    vecs.push_back('{name:"s_m7_2",     sgn:1'b1, a:32'hFFFF_FFF9,  b:32'd2,          res:{32'hFFFF_FFFF,  32'hFFFF_FFFD}});
    vecs.push_back('{name:"s_7_m2",     sgn:1'b1, a:32'd7,          b:32'hFFFF_FFFE,  res:{32'h0000_0001,  32'hFFFF_FFFD}});
    vecs.push_back('{name:"s_m7_m2",    sgn:1'b1, a:32'hFFFF_FFF9,  b:32'hFFFF_FFFE,  res:{32'hFFFF_FFFF,  32'h0000_0003}});
    vecs.push_back('{name:"u_m7_2",     sgn:1'b0, a:32'hFFFF_FFF9,  b:32'd2,          res:{32'h0000_0001,  32'h7FFF_FFFC}});
    vecs.push_back('{name:"s_ovf",      sgn:1'b1, a:32'h8000_0000,  b:32'hFFFF_FFFF,  res:{32'h0,          32'h8000_0000}});
    vecs.push_back('{name:"u_max_1",    sgn:1'b0, a:32'hFFFF_FFFF,  b:32'd1,          res:{32'h0,          32'hFFFF_FFFF}});
    vecs.push_back('{name:"u_max_half", sgn:1'b0, a:32'hFFFF_FFFF,  b:32'h8000_0000,  res:{32'h7FFF_FFFF,  32'h0000_0001}});
    vecs.push_back('{name:"u_dz",       sgn:1'b0, a:32'd5,          b:32'd0,          res:{32'd5,          32'hFFFF_FFFF}});
    vecs.push_back('{name:"s_dz",       sgn:1'b1, a:32'd5,          b:32'd0,          res:{32'd5,          32'hFFFF_FFFF}});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {63'd0, dif.busy}, 64'd0);
    check("rst_done",   {63'd0, dif.done}, 64'd0);
    check("rst_result", dif.result,        64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, issued back to back.
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res);

    // Cancel at cycle 10 of a divide, new start at cycle 11.
    dif.start      = 1'b1;
    dif.signed_div = 1'b0;
    dif.a          = 32'd1000;
    dif.b          = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("cancel_busy", {63'd0, dif.busy}, 64'd1);
      @(posedge clk);
      #1;
      dif.start = 1'b0;
    end
    dif.cancel = 1'b1;
    @(negedge clk);
    check("cancel_busy_c10", {63'd0, dif.busy}, 64'd1);
    @(posedge clk);
    #1;
    dif.cancel = 1'b0;
    #1;
    check("cancel_busy_c11", {63'd0, dif.busy}, 64'd0);
    check("cancel_result_kept", dif.result, last_res);
    run_op("after_cancel", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8});

    // Cancel together with start in IDLE: nothing begins.
    dif.start  = 1'b1;
    dif.cancel = 1'b1;
    dif.a      = 32'd77;
    dif.b      = 32'd7;
    #1;
    check("cancel_start_busy", {63'd0, dif.busy}, 64'd0);
    @(posedge clk);
    #1;
    dif.start  = 1'b0;
    dif.cancel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cancel_start_idle", {63'd0, dif.busy}, 64'd0);
    end
    check("cancel_start_result", dif.result, last_res);
    @(posedge clk);
    #1;

    // Async reset in CALC at count 20, between clock edges.
    dif.start      = 1'b1;
    dif.signed_div = 1'b0;
    dif.a          = 32'd200;
    dif.b          = 32'd7;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      check("pre_rst_busy", {63'd0, dif.busy}, 64'd1);
      @(posedge clk);
      #1;
      dif.start = 1'b0;
    end
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy",   {63'd0, dif.busy}, 64'd0);
    check("async_rst_done",   {63'd0, dif.done}, 64'd0);
    check("async_rst_result", dif.result,        64'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("after_rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Quiet tail: any stray done is caught by the monitor.
    repeat (3) @(posedge clk);
    #1;
    check("final_result", dif.result, last_res);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
